// File: rtl/sync_debounce_pkg.sv
// sync_pkg: shared defaults and counter sizing for the debounced synchronizer.
package sync_pkg;

    localparam int DEF_STAGES   = 2;
    localparam int DEF_DEBOUNCE = 3;

    function automatic int cnt_width(input int debounce);
        return $clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one channel -- synchronizer chain, stability counter,
// debounced level and registered rise/fall pulses.
module debounce_channel
    import sync_pkg::*;
#(
    parameter int STAGES   = DEF_STAGES,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(DEBOUNCE);

    if (STAGES < 2) begin : g_bad_stages
        $error("debounce_channel: STAGES must be 2 or more");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("debounce_channel: DEBOUNCE must be 1 or more");
    end

    logic [STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              s;
    logic              toggle;

    assign s = sync_q[STAGES-1];

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], in};
        toggle  = (s != level_q) && (cnt_q == CW'(DEBOUNCE - 1));
        // counter saturates by construction: it clears on toggle before it can pass DEBOUNCE-1
        cnt_d   = (s == level_q || toggle) ? '0 : cnt_q + CW'(1);
        level_d = toggle ? s : level_q;
        rise_d  = toggle & s;
        fall_d  = toggle & ~s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: WIDTH independent synchronized, debounced channels with
// per-channel edge pulses.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STAGES   = DEF_STAGES,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STAGES   (STAGES),
            .DEBOUNCE (DEBOUNCE)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .in    (in[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: per-cycle vector table with a scoreboard queue, plus
// hand-written latency and asynchronous-reset sequences.
module tb_sync_debounce;

    typedef struct {
        logic       rst;
        logic [3:0] in;
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    typedef struct {
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in  = 4'h0;
    logic [3:0] level, rise, fall;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];
    exp_t sb_q[$];

    sync_debounce #(.WIDTH(4), .STAGES(2), .DEBOUNCE(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] i, input logic [3:0] l,
                       input logic [3:0] ri, input logic [3:0] f, input int n);
        for (int k = 0; k < n; k++) vecs.push_back('{r, i, l, ri, f});
    endtask

    initial begin
        exp_t e;
        int   n;
        // simultaneous rise on all channels out of reset
        add(1, 4'hF, 4'h0, 4'h0, 4'h0, 2);
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 4);
        add(0, 4'hF, 4'hF, 4'hF, 4'h0, 1);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 1);
        // ch0 held high, ch1 two-cycle glitch ignored
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h3, 4'h0, 4'h0, 4'h0, 2);
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 2);
        add(0, 4'h1, 4'h1, 4'h1, 4'h0, 1);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 2);
        // ch2 rise then fall
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h4, 4'h0, 4'h0, 4'h0, 4);
        add(0, 4'h4, 4'h4, 4'h4, 4'h0, 1);
        add(0, 4'h4, 4'h4, 4'h0, 4'h0, 1);
        add(0, 4'h0, 4'h4, 4'h0, 4'h0, 4);
        add(0, 4'h0, 4'h0, 4'h0, 4'h4, 1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        // ch3 partial count discarded by reset
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h8, 4'h0, 4'h0, 4'h0, 2);
        add(1, 4'h8, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h8, 4'h0, 4'h0, 4'h0, 4);
        add(0, 4'h8, 4'h8, 4'h8, 4'h0, 1);
        add(0, 4'h8, 4'h8, 4'h0, 4'h0, 1);
        // 0->5, one-cycle dropout ignored, then genuine fall
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h5, 4'h0, 4'h0, 4'h0, 4);
        add(0, 4'h5, 4'h5, 4'h5, 4'h0, 1);
        add(0, 4'h5, 4'h5, 4'h0, 4'h0, 1);
        add(0, 4'h0, 4'h5, 4'h0, 4'h0, 1);
        add(0, 4'h5, 4'h5, 4'h0, 4'h0, 4);
        add(0, 4'h0, 4'h5, 4'h0, 4'h0, 4);
        add(0, 4'h0, 4'h0, 4'h0, 4'h5, 1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 1);

        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge clk);
            rst = vecs[v].rst;
            in  = vecs[v].in;
            sb_q.push_back('{vecs[v].level, vecs[v].rise, vecs[v].fall});
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check($sformatf("sb_empty[%0d]", v), 1, 0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("level[%0d]", v), {28'h0, level}, {28'h0, e.level});
                check($sformatf("rise[%0d]", v),  {28'h0, rise},  {28'h0, e.rise});
                check($sformatf("fall[%0d]", v),  {28'h0, fall},  {28'h0, e.fall});
                check($sformatf("rise_and_fall[%0d]", v), {28'h0, rise & fall}, 0);
            end
        end

        // latency: first edge after deassert samples in; rise expected on the 5th edge
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in  = 4'hA;
        n   = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (rise != 4'h0) break;
        end
        check("rise_latency_edges", n, 5);
        check("rise_latency_value", {28'h0, rise}, 32'hA);
        @(posedge clk);
        #1;
        check("rise_one_cycle", {28'h0, rise}, 0);
        check("level_held", {28'h0, level}, 32'hA);

        // asynchronous reset between edges clears outputs without a clock edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_level", {28'h0, level}, 0);
        check("async_rst_pulses", {24'h0, rise, fall}, 0);
        @(negedge clk);
        rst = 1'b0;
        in  = 4'h0;
        repeat (6) @(posedge clk);
        #1;
        check("no_pulse_after_rst", {24'h0, rise, fall}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
